// File: rtl/alu_seq.sv
// Handshaked W-bit ALU with Z/V/N/err status; `define ALU_MUL_EN builds the iterative shift-add MUL (op 111).
// Latency 1 (MUL: W+1); result held until out_ready, in_ready follows out_ready while a result is pending.
module alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] Ain,
  input  logic [W-1:0] Bin,
  input  logic [2:0]   ALUop,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         Z,
  output logic         V,
  output logic         N,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           z_q, z_d;
  logic           v_q, v_d;
  logic           n_q, n_d;
  logic           err_q, err_d;

  logic           accept;
  logic           mul_start;
  logic           mul_last;

  logic [W-1:0]   alu_res;
  logic           alu_v;
  logic           alu_err;

  assign accept = in_valid & in_ready;

  // Single-cycle datapath; op 111 only reaches the result registers when MUL is not built.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[W-1] == Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
      end
      OP_SUB: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[W-1] != Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
      end
      OP_AND: alu_res = Ain & Bin;
      OP_NOT: alu_res = ~Bin;
      OP_LSL: alu_res = {Bin[W-2:0], 1'b0};
      OP_LSR: alu_res = {1'b0, Bin[W-1:1]};
      OP_ASR: alu_res = {Bin[W-1], Bin[W-1:1]};
      OP_MUL: begin
`ifdef ALU_MUL_EN
        alu_err = 1'b0;
`else
        alu_err = 1'b1;
`endif
      end
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(W) + 1;

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mul_start = accept && (ALUop == OP_MUL);
  assign mul_last  = (state_q == S_EXEC) && (cnt_q == CNT_W'(W - 1));

  // Operands are captured at accept; EXEC consumes one multiplier bit per cycle.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (mul_start) begin
      mcand_d  = {{W{1'b0}}, Ain};
      mplier_d = Bin;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == S_EXEC) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = {mcand_q[2*W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[W-1:1]};
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign mul_start = 1'b0;
  assign mul_last  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = mul_start ? S_EXEC : S_DONE;
        end
      end
      S_EXEC: begin
        if (mul_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (accept) begin
          state_d = mul_start ? S_EXEC : S_DONE;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: in_ready = reset_n;
      S_EXEC: in_ready = 1'b0;
      S_DONE: begin
        in_ready  = reset_n & out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Result/flags change only on a single-cycle accept or the final MUL step; otherwise they hold.
  always_comb begin
    out_d = out_q;
    z_d   = z_q;
    v_d   = v_q;
    n_d   = n_q;
    err_d = err_q;
    if (accept && !mul_start) begin
      out_d = alu_res;
      z_d   = (alu_res == '0);
      n_d   = alu_res[W-1];
      v_d   = alu_v;
      err_d = alu_err;
    end
`ifdef ALU_MUL_EN
    else if (mul_last) begin
      out_d = acc_d[W-1:0];
      z_d   = (acc_d[W-1:0] == '0);
      n_d   = acc_d[W-1];
      v_d   = |acc_d[2*W-1:W];
      err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q <= '0;
      z_q   <= 1'b0;
      v_q   <= 1'b0;
      n_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      z_q   <= z_d;
      v_q   <= v_d;
      n_q   <= n_d;
      err_q <= err_d;
    end
  end

  assign out = out_q;
  assign Z   = z_q;
  assign V   = v_q;
  assign N   = n_q;
  assign err = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  Ain, Bin, out;
  logic [2:0]    ALUop;
  logic          Z, V, N, err;

  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]    Ain8, Bin8, out8;
  logic [2:0]    ALUop8;
  logic          Z8, V8, N8, err8;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .Z(Z), .V(V), .N(N), .err(err)
  );

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .Ain(Ain8), .Bin(Bin8), .ALUop(ALUop8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .Z(Z8), .V(V8), .N(N8), .err(err8)
  );

  // Reference: {err, V, N, Z, out} from signed/unsigned integer arithmetic.
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, ua, ub, t;
    logic [15:0] r;
    logic v, e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    v = 1'b0; e = 1'b0; t = 0;
    case (op)
      3'd0: begin t = sa + sb; v = (t > 32767) || (t < -32768); end
      3'd1: begin t = sa - sb; v = (t > 32767) || (t < -32768); end
      3'd2: t = ua & ub;
      3'd3: t = 65535 - ub;
      3'd4: t = ub * 2;
      3'd5: t = ub / 2;
      3'd6: t = (sb >= 0) ? sb / 2 : -((-sb + 1) / 2);
      default: begin
`ifdef ALU_MUL_EN
        t = ua * ub; v = (t > 65535);
`else
        t = 0; e = 1'b1;
`endif
      end
    endcase
    r = t[15:0];
    return {e, v, (r >= 16'h8000), (r == 16'h0000), r};
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; ALUop = 3'd0; Ain = 16'h1234; Bin = 16'h1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++;
    if ({out_valid, out, Z, V, N, err} !== 21'd0)
      begin failures++; $display("FAIL reset_state got=%b_%h_%b%b%b%b want=0_0000_0000", out_valid, out, Z, V, N, err); end
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL reset_release got=%b%b want=10", in_ready, out_valid); end
  endtask

  task automatic test_add_overflow();
    @(posedge clk); #1;
    Ain = 16'h7FFF; Bin = 16'h0001; ALUop = 3'b000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out, Z, V, N, err} !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0})
      begin failures++; $display("FAIL add_ovf got=%b_%h ZVNe=%b%b%b%b want=1_8000 ZVNe=0110", out_valid, out, Z, V, N, err); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out} !== {1'b0, 16'h8000}) begin failures++; $display("FAIL add_retain got=%b_%h want=0_8000", out_valid, out); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    Ain = 16'h0005; Bin = 16'h0005; ALUop = 3'b001; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    Ain = 16'($urandom); Bin = 16'hFFFF; ALUop = 3'b011;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out, Z, V, N} !== {1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0})
      begin failures++; $display("FAIL b2b_sub got=vld%b rdy%b %h ZVN=%b%b%b want=vld1 rdy1 0000 ZVN=100", out_valid, in_ready, out, Z, V, N); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out, Z, V, N} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0})
      begin failures++; $display("FAIL b2b_not got=vld%b %h ZVN=%b%b%b want=vld1 0000 ZVN=100", out_valid, out, Z, V, N); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b want=0", out_valid); end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    Ain = 16'h0F0F; Bin = 16'h8002; ALUop = 3'b110; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    Ain = 16'h0001; Bin = 16'h0001; ALUop = 3'b000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out, Z, V, N, err} !== {1'b1, 1'b0, 16'hC001, 1'b0, 1'b0, 1'b1, 1'b0})
        begin failures++; $display("FAIL hold_asr cyc=%0d got=vld%b rdy%b %h ZVNe=%b%b%b%b want=vld1 rdy0 c001 ZVNe=0010", k, out_valid, in_ready, out, Z, V, N, err); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out} !== {1'b1, 1'b1, 16'hC001})
      begin failures++; $display("FAIL hold_release got=vld%b rdy%b %h want=vld1 rdy1 c001", out_valid, in_ready, out); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out} !== {1'b0, 16'hC001}) begin failures++; $display("FAIL hold_single got=%b_%h want=0_c001", out_valid, out); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    @(posedge clk); #1;
    Ain = 16'h0100; Bin = 16'h0100; ALUop = 3'b111; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      Ain = 16'($urandom); Bin = 16'($urandom);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b00) begin failures++; $display("FAIL mul_busy cyc=%0d got=rdy%b vld%b want=rdy0 vld0", k, in_ready, out_valid); end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out, Z, V, N, err} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0})
      begin failures++; $display("FAIL mul_result got=vld%b %h ZVNe=%b%b%b%b want=vld1 0000 ZVNe=1100", out_valid, out, Z, V, N, err); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_reset();
    @(posedge clk); #1;
    Ain = 16'h0003; Bin = 16'h0005; ALUop = 3'b111; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mulrst_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out, Z, V, N, err} !== {1'b0, 1'b1, 16'h0000, 4'b0000})
      begin failures++; $display("FAIL mulrst_state got=vld%b rdy%b %h ZVNe=%b%b%b%b want=vld0 rdy1 0000 ZVNe=0000", out_valid, in_ready, out, Z, V, N, err); end
    @(posedge clk); #1;
    Ain = 16'h0001; Bin = 16'h0001; ALUop = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out} !== {1'b1, 16'h0002}) begin failures++; $display("FAIL mulrst_add got=%b_%h want=1_0002", out_valid, out); end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_mul_disabled();
    @(posedge clk); #1;
    Ain = 16'h0003; Bin = 16'h0005; ALUop = 3'b111; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out, Z, V, N, err} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1})
      begin failures++; $display("FAIL nomul_err got=vld%b %h ZVNe=%b%b%b%b want=vld1 0000 ZVNe=1001", out_valid, out, Z, V, N, err); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_w8();
    @(posedge clk); #1;
    Ain8 = 8'h7F; Bin8 = 8'h01; ALUop8 = 3'b000; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    Ain8 = 8'h00; Bin8 = 8'h81; ALUop8 = 3'b110;
    @(negedge clk);
    checks++;
    if ({out_valid8, out8, Z8, V8, N8, err8} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0})
      begin failures++; $display("FAIL w8_add got=vld%b %h ZVNe=%b%b%b%b want=vld1 80 ZVNe=0110", out_valid8, out8, Z8, V8, N8, err8); end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid8, out8, Z8, V8, N8} !== {1'b1, 8'hC0, 1'b0, 1'b0, 1'b1})
      begin failures++; $display("FAIL w8_asr got=vld%b %h ZVN=%b%b%b want=vld1 c0 ZVN=001", out_valid8, out8, Z8, V8, N8); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [19:0] q[$];
    logic [19:0] exp_v, obs, held;
    logic        held_vld;
    held_vld = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 640) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        ALUop     = ($urandom_range(0, 9) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
        Ain       = pick_operand();
        Bin       = pick_operand();
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      obs = {err, V, N, Z, out};
      if (held_vld) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held)
          begin failures++; $display("FAIL rnd_hold cyc=%0d got=vld%b %h want=vld1 %h", cyc, out_valid, obs, held); end
      end
      held_vld = out_valid && !out_ready;
      held     = obs;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rnd_spurious cyc=%0d got=%h want=no output", cyc, obs);
        end else begin
          exp_v = q.pop_front();
          if (obs !== exp_v) begin failures++; $display("FAIL rnd_result cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
        end
      end
      if (in_valid && in_ready) q.push_back(model(ALUop, Ain, Bin));
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d pending want=0", q.size()); end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Ain = '0; Bin = '0; ALUop = 3'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; Ain8 = '0; Bin8 = '0; ALUop8 = 3'd0;
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_hold();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    test_w8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
